// File: rtl/bridge_pkg.sv
// Shared register offsets and status-word layout for the host-to-core instruction bridge.
package bridge_pkg;

  // OBI register offsets, decoded from addr[3:2]
  localparam logic [1:0] BRIDGE_OFF_INSTR  = 2'd0;
  localparam logic [1:0] BRIDGE_OFF_STATUS = 2'd1;
  localparam logic [1:0] BRIDGE_OFF_ADDR   = 2'd2;
  localparam logic [1:0] BRIDGE_OFF_RESULT = 2'd3;

  // Bit positions inside the 16-bit host status word
  localparam int unsigned ST_ADDR_VALID     = 0;
  localparam int unsigned ST_OVERFLOW       = 1;
  localparam int unsigned ST_UNDERFLOW      = 2;
  localparam int unsigned ST_RESULT_PENDING = 3;
  localparam int unsigned ST_COUNT_LSB      = 8;
  localparam int unsigned ST_COUNT_W        = 8;
  localparam int unsigned STATUS_W          = 16;

  // Number of byte lanes on the OBI data bus
  localparam int unsigned BE_W = 4;

endpackage

// File: rtl/bridge_sync_fifo.sv
// Single-clock register-array FIFO; push is dropped when full, pop ignored when empty.
module bridge_sync_fifo #(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pDEPTH      = 8
) (
  input  logic                             clk,
  input  logic                             reset_i,
  input  logic                             push,
  input  logic                             pop,
  input  logic [pDATA_WIDTH-1:0]           wdata,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(pDEPTH+1)-1:0]      count,
  output logic [pDATA_WIDTH-1:0]           head
);

  localparam int unsigned AW = $clog2(pDEPTH);
  localparam int unsigned CW = $clog2(pDEPTH + 1);

  logic [pDATA_WIDTH-1:0] mem [pDEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   push_en;
  logic                   pop_en;

  assign full    = (count == CW'(pDEPTH));
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_en) - CW'(pop_en);
    end
  end

endmodule

// File: rtl/bridge_instr_fifo_obi.sv
// Host-to-core bridge: instruction FIFO, section-address mailbox and result mailbox on an OBI slave port.
module bridge_instr_fifo_obi
  import bridge_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH     = 32,
  parameter int unsigned pDEPTH          = 8,
  parameter int unsigned pSTALL_ON_EMPTY = 1
) (
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic                   host_instr_we,
  input  logic [pDATA_WIDTH-1:0] host_instr,
  input  logic                   host_addr_we,
  input  logic [pDATA_WIDTH-1:0] host_addr,
  input  logic                   host_result_ack,
  input  logic                   host_flag_clr,
  output logic [15:0]            host_status,
  output logic [pDATA_WIDTH-1:0] host_result,
  input  logic                   req,
  input  logic                   we,
  input  logic [3:0]             be,
  input  logic [pDATA_WIDTH-1:0] addr,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   gnt,
  output logic                   rvalid,
  output logic [pDATA_WIDTH-1:0] rdata
);

  localparam int unsigned CW     = $clog2(pDEPTH + 1);
  localparam int unsigned LANE_W = pDATA_WIDTH / BE_W;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [pDATA_WIDTH-1:0] fifo_head;

  logic [pDATA_WIDTH-1:0] addr_mbox;
  logic                   addr_valid;
  logic                   result_pending;
  logic                   overflow;
  logic                   underflow;

  logic [1:0]             sel;
  logic                   is_read;
  logic                   instr_rd;
  logic                   stall;
  logic                   xfer;
  logic                   addr_rd;
  logic                   result_wr;
  logic [pDATA_WIDTH-1:0] rd_data;
  logic [pDATA_WIDTH-1:0] result_merged;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[pDATA_WIDTH-1:4], addr[1:0]};

  // Request decode and grant; only an empty-FIFO INSTR read can be held off
  assign sel       = addr[3:2];
  assign is_read   = req & ~we;
  assign instr_rd  = is_read & (sel == BRIDGE_OFF_INSTR);
  assign stall     = instr_rd & fifo_empty & (pSTALL_ON_EMPTY != 0);
  assign gnt       = req & ~stall;
  assign xfer      = req & gnt;
  assign addr_rd   = xfer & ~we & (sel == BRIDGE_OFF_ADDR);
  assign result_wr = xfer & we & (sel == BRIDGE_OFF_RESULT);

  bridge_sync_fifo #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pDEPTH      (pDEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_i (reset_i),
    .push    (host_instr_we),
    .pop     (xfer & instr_rd),
    .wdata   (host_instr),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (fifo_head)
  );

  // Host status word assembled from registered state
  always_comb begin
    host_status                              = '0;
    host_status[ST_ADDR_VALID]               = addr_valid;
    host_status[ST_OVERFLOW]                 = overflow;
    host_status[ST_UNDERFLOW]                = underflow;
    host_status[ST_RESULT_PENDING]           = result_pending;
    host_status[ST_COUNT_LSB +: ST_COUNT_W]  = ST_COUNT_W'(fifo_count);
  end

  // Read-data mux; writes and empty pops return zero
  always_comb begin
    rd_data = '0;
    if (!we) begin
      unique case (sel)
        BRIDGE_OFF_INSTR:  rd_data = fifo_empty ? '0 : fifo_head;
        BRIDGE_OFF_STATUS: rd_data = pDATA_WIDTH'(host_status);
        BRIDGE_OFF_ADDR:   rd_data = addr_mbox;
        BRIDGE_OFF_RESULT: rd_data = host_result;
        default:           rd_data = '0;
      endcase
    end
  end

  // Byte-lane merge of OBI write data into the result mailbox
  always_comb begin
    result_merged = host_result;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) result_merged[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
    end
  end

  // Address and result mailboxes; host load beats core clear, core write beats host ack
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      addr_mbox      <= '0;
      addr_valid     <= 1'b0;
      host_result    <= '0;
      result_pending <= 1'b0;
    end else begin
      if (host_addr_we) begin
        addr_mbox  <= host_addr;
        addr_valid <= 1'b1;
      end else if (addr_rd) begin
        addr_valid <= 1'b0;
      end
      if (result_wr) begin
        host_result    <= result_merged;
        result_pending <= 1'b1;
      end else if (host_result_ack) begin
        result_pending <= 1'b0;
      end
    end
  end

  // Sticky error flags; a same-cycle set overrides the host clear
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (host_instr_we & fifo_full) | (overflow & ~host_flag_clr);
      underflow <= (xfer & instr_rd & fifo_empty) | (underflow & ~host_flag_clr);
    end
  end

  // One-cycle OBI response for every granted request
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= xfer;
      rdata  <= xfer ? rd_data : '0;
    end
  end

endmodule
